// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC link defaults
// Purpose: flit width and router input-buffer depth defaults, plus the
//          credit-counter width helper shared by NoC link endpoints.
// Ports:   none (package).
package noc_pkg;

  localparam int NOC_FW = 36;
  localparam int NOC_B  = 4;

  // A counter that must hold every value 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - single-clock flit FIFO
// Purpose: small power-of-two-deep FIFO used on both ends of a NoC link.
//          Pushes into a full FIFO and pops from an empty FIFO are ignored.
//          rdata shows the head entry combinationally.
// Ports:   clk, rst (async active-high)
//          push, wdata        - write side
//          pop, rdata         - read side
//          count, full, empty - occupancy
module noc_sync_fifo #(
  parameter int  FW    = 36,
  parameter int  D     = 4,
  localparam int PW    = $clog2(D),
  localparam int CNT_W = $clog2(D + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [FW-1:0]    wdata,
  output logic [FW-1:0]    rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [FW-1:0] mem [D];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CNT_W'(D));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage is not reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= wdata;
    end
  end

  // D is a power of two, so pointer overflow is the modulo-D wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PW'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_flit_injector.sv
// rtl/noc_flit_injector.sv - credit-gated flit transmitter into a router port
// Purpose: buffers local packets (one flit each) in a FIFO and emits them to
//          a router input port as a one-cycle write strobe plus data, gated
//          by a credit counter mirroring the router's free buffer slots.
// Ports:   clk, rst (async active-high)
//          pkt_valid, pkt_data, pkt_ready - local packet handshake
//          flit_out_wr, flit_out          - registered flit strobe/data
//          credit_in                      - credit-return pulse from router
//          credit_avail                   - current credit count
//          fifo_empty                     - local FIFO holds no flits
//          err_credit_ovf                 - sticky credit-overflow error
//          sent_cnt, stall_cnt            - only with NOC_FLIT_INJECTOR_STATS_EN
// Config:  define NOC_FLIT_INJECTOR_STATS_EN to add the statistics counters.
module noc_flit_injector
  import noc_pkg::*;
#(
  parameter int  FW = NOC_FW,
  parameter int  B  = NOC_B,
  parameter int  D  = 4,
  localparam int CW = credit_width(B)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pkt_valid,
  input  logic [FW-1:0] pkt_data,
  output logic          pkt_ready,
  output logic          flit_out_wr,
  output logic [FW-1:0] flit_out,
  input  logic          credit_in,
  output logic [CW-1:0] credit_avail,
  output logic          fifo_empty,
`ifdef NOC_FLIT_INJECTOR_STATS_EN
  output logic [31:0]   sent_cnt,
  output logic [31:0]   stall_cnt,
`endif
  output logic          err_credit_ovf
);

  localparam int CNT_W = $clog2(D + 1);

  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             head_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [FW-1:0]    head;
  logic [CW-1:0]    credit;

  // Readiness comes from registered occupancy only, so a full FIFO refuses
  // a packet even in a cycle where the head is leaving.
  assign pkt_ready    = !fifo_full;
  assign push         = pkt_valid && pkt_ready;
  assign pop          = !head_empty && (credit != '0);
  assign fifo_empty   = (fifo_count == '0);
  assign credit_avail = credit;

  noc_sync_fifo #(
    .FW (FW),
    .D  (D)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (pkt_data),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (head_empty)
  );

  // Credit counter. A send and a returned credit in the same cycle cancel.
  // A return while already at B cannot correspond to any sent flit, so the
  // count is held and the error latches until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit         <= CW'(B);
      err_credit_ovf <= 1'b0;
    end else begin
      case ({pop, credit_in})
        2'b10: credit <= credit - CW'(1);
        2'b01: begin
          if (credit == CW'(B)) begin
            err_credit_ovf <= 1'b1;
          end else begin
            credit <= credit + CW'(1);
          end
        end
        default: credit <= credit;
      endcase
    end
  end

  // Output register: data holds its last value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_out_wr <= 1'b0;
      flit_out    <= '0;
    end else begin
      flit_out_wr <= pop;
      if (pop) begin
        flit_out <= head;
      end
    end
  end

`ifdef NOC_FLIT_INJECTOR_STATS_EN
  // sent_cnt wraps naturally; stall_cnt saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (flit_out_wr) begin
        sent_cnt <= sent_cnt + 32'd1;
      end
      if (!fifo_empty && (credit == '0) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
